out_buffer: RTL and testbench
=============================

OUT_BUFFER -- requirements
Module: out_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of a machine output word (matches t_data).
REQ-002 SHALL have parameter DEPTH, default 4, number of buffer entries (power of two, >= 2).
REQ-003 SHALL have parameter SKID, default 2, free-entry margin at which upstream stall is requested (1 <= SKID < DEPTH).
REQ-004 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: dataoutv_in  in  1  output-word valid from the x3 outputs register.
REQ-007 SHALL have ports: dataout_in  in  DATA_W  output word from the x3 outputs register.
REQ-008 SHALL have ports: stalled_in  in  1  pipeline-stalled flag from the x3 outputs register.
REQ-009 SHALL have ports: out_valid  out  1  buffer head holds a word for the external consumer.
REQ-010 SHALL have ports: out_data  out  DATA_W  buffer head word.
REQ-011 SHALL have ports: out_ready  in  1  external consumer accepts the head word.
REQ-012 SHALL have ports: stall_req  out  1  request to the pipeline to stall issue.
REQ-013 SHALL have ports: count  out  $clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have ports: overflow  out  1  sticky, a word was dropped on a full buffer.
REQ-015 SHALL have ports: drop_cnt  out  8  dropped-word counter (see Configuration).

Function
REQ-016 SHALL define push = dataoutv_in & ~stalled_in; words presented while stalled_in=1 are bubbles and SHALL be ignored.
REQ-017 SHALL define pop = out_valid & out_ready.
REQ-018 SHALL store entries in a circular array with write/read pointers wrapping DEPTH-1 -> 0.
REQ-019 SHALL make a pushed word visible at out_valid/out_data on the cycle after the push (latency 1, no combinational bypass).
REQ-020 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer, both from registered state only.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on push with count < DEPTH, write the word and advance the write pointer.
REQ-023 SHALL, on push with count == DEPTH and pop in the same cycle, accept the push (count stays DEPTH).
REQ-024 SHALL, on push with count == DEPTH and no pop, drop the word, leave the array and pointers unchanged, and set overflow.
REQ-025 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and advance both pointers.
REQ-026 SHALL ignore pop when count == 0 (out_valid=0 makes it impossible).
REQ-027 SHALL drive stall_req = (count >= DEPTH - SKID), registered from the next-state count so it rises the cycle count reaches the threshold.
REQ-028 SHALL preserve words in arrival order; no reordering, no duplication.

Reset
REQ-029 SHALL, on reset_n=0 at any time, asynchronously clear pointers, count, overflow, drop_cnt, out_valid and stall_req to 0; array contents need not be cleared.
REQ-030 SHALL discard any buffered words when reset asserts mid-stream; first push after release lands in entry 0.
REQ-031 SHALL ignore push and pop on the first rising edge where reset_n is 0.

Configuration
REQ-032 SHALL, with OUT_BUFFER_DROP_CNT_EN defined, increment drop_cnt on every dropped word (REQ-024), saturating at 255, cleared only by reset.
REQ-033 SHALL, without OUT_BUFFER_DROP_CNT_EN, tie drop_cnt to 0 and contain no counter logic; overflow behaviour unchanged.

Verification
REQ-034 SHALL cover: push 0x0011,0x0022,0x0033 on consecutive cycles, out_ready=1 -> out_data 0x0011,0x0022,0x0033 on cycles 1,2,3 after each push, count never exceeds 1.
REQ-035 SHALL cover: out_ready=0, push 4 words (DEPTH=4,SKID=2) -> stall_req=1 after 2nd push, count=4, overflow=0; 5th push 0xDEAD -> dropped, overflow=1, drop_cnt=1 with macro, 0 without.
REQ-036 SHALL cover: count=4, push 0xBEEF with out_ready=1 same cycle -> head popped, 0xBEEF accepted, count=4, overflow=0.
REQ-037 SHALL cover: dataoutv_in=1, stalled_in=1 for 3 cycles -> count stays 0, out_valid=0.
REQ-038 SHALL cover: count=3, reset_n pulsed low mid-cycle -> out_valid, count, stall_req, overflow 0 immediately; next push 0x0055 appears at out_data one cycle later.
REQ-039 SHALL cover: with macro, 300 drops on full buffer -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/out_buffer.sv
// -----------------------------------------------------------------------------
// out_buffer
// Small circular buffer between the x3 outputs register and an external
// valid/ready consumer. It asks the pipeline to stall before it fills. Once
// full, it drops words that it cannot accept and records the drop in the
// sticky overflow flag.
//
// Optional feature: define OUT_BUFFER_DROP_CNT_EN to build a saturating 8-bit
// dropped-word counter on drop_cnt. Without it, drop_cnt is tied to zero.
// -----------------------------------------------------------------------------
module out_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int SKID   = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       dataoutv_in,
    input  logic [DATA_W-1:0]          dataout_in,
    input  logic                       stalled_in,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       stall_req,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - SKID);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              out_valid_r;
    logic              stall_req_r;
    logic              overflow_r;

    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;

    // Decode the push and pop requests, and decide between accept and drop.
    always_comb begin
        push_s  = dataoutv_in & ~stalled_in;
        pop_s   = out_valid_r & out_ready;
        full_s  = (count_r == CNT_FULL);
        // On a full buffer, a pop in the same cycle frees the slot for the push.
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
    end

    // Compute the next occupancy and the next pointer positions, wrapping explicitly.
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (wr_en_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == PTR_LAST) ? PTR_ZERO : (wr_ptr_r + PTR_ONE);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == PTR_LAST) ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Control state. out_valid and stall_req are registered from the next count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
            stall_req_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
            stall_req_r <= (count_nxt_s >= CNT_STALL);
            overflow_r  <= overflow_r | drop_s;
        end
    end

    // Storage array. Contents are not reset because occupancy qualifies every read.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= dataout_in;
        end
    end

`ifdef OUT_BUFFER_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Count dropped words, saturating at 255. Only reset clears the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

    assign out_valid = out_valid_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign stall_req = stall_req_r;
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_out_buffer
// Directed-vector bench for out_buffer with DEPTH=4 and SKID=2. Every expected
// value is written out by hand. The expected drop_cnt follows
// OUT_BUFFER_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_out_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int SKID   = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

`ifdef OUT_BUFFER_DROP_CNT_EN
    localparam int EXP_DROP1   = 1;
    localparam int EXP_DROPSAT = 255;
`else
    localparam int EXP_DROP1   = 0;
    localparam int EXP_DROPSAT = 0;
`endif

    logic              clock;
    logic              reset_n;
    logic              dataoutv_in;
    logic [DATA_W-1:0] dataout_in;
    logic              stalled_in;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              stall_req;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_vec;
    int n_miss;

    out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dataoutv_in (dataoutv_in),
        .dataout_in  (dataout_in),
        .stalled_in  (stalled_in),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stall_req   (stall_req),
        .count       (count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [15:0] w);
        dataoutv_in = 1'b1;
        dataout_in  = w;
        step();
        dataoutv_in = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        logic [15:0] exp_q [4];
        n_vec       = 0;
        n_miss      = 0;
        reset_n     = 1'b0;
        dataoutv_in = 1'b0;
        dataout_in  = 16'h0000;
        stalled_in  = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_stall",    32'(stall_req), 32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_drop",     32'(drop_cnt),  32'd0);
        reset_n = 1'b1;
        step();

        // Streaming with the consumer always ready: latency 1, occupancy stays at 1.
        out_ready   = 1'b1;
        dataoutv_in = 1'b1;
        dataout_in  = 16'h0011;
        step();
        chk("strm_v1", 32'(out_valid), 32'd1);
        chk("strm_d1", 32'(out_data),  32'h0011);
        chk("strm_c1", 32'(count),     32'd1);
        dataout_in = 16'h0022;
        step();
        chk("strm_d2", 32'(out_data),  32'h0022);
        chk("strm_c2", 32'(count),     32'd1);
        dataout_in = 16'h0033;
        step();
        chk("strm_d3", 32'(out_data),  32'h0033);
        chk("strm_c3", 32'(count),     32'd1);
        dataoutv_in = 1'b0;
        step();
        chk("strm_empty", 32'(out_valid), 32'd0);
        chk("strm_c0",    32'(count),     32'd0);

        // Fill with the consumer stalled, then overflow.
        out_ready = 1'b0;
        push_word(16'h00A1);
        chk("fill_c1", 32'(count),     32'd1);
        chk("fill_s1", 32'(stall_req), 32'd0);
        push_word(16'h00A2);
        chk("fill_c2", 32'(count),     32'd2);
        chk("fill_s2", 32'(stall_req), 32'd1);
        push_word(16'h00A3);
        push_word(16'h00A4);
        chk("fill_c4",   32'(count),    32'd4);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        push_word(16'hDEAD);
        chk("drop_c4",   32'(count),    32'd4);
        chk("drop_ovf",  32'(overflow), 32'd1);
        chk("drop_cnt1", 32'(drop_cnt), 32'(EXP_DROP1));
        chk("drop_head", 32'(out_data), 32'h00A1);

        // A push on a full buffer with a pop in the same cycle is accepted.
        do_reset();
        chk("rst2_ovf", 32'(overflow), 32'd0);
        push_word(16'h00B1);
        push_word(16'h00B2);
        push_word(16'h00B3);
        push_word(16'h00B4);
        chk("full_c4", 32'(count), 32'd4);
        out_ready = 1'b1;
        push_word(16'hBEEF);
        chk("fpp_c4",  32'(count),    32'd4);
        chk("fpp_ovf", 32'(overflow), 32'd0);
        exp_q[0] = 16'h00B2;
        exp_q[1] = 16'h00B3;
        exp_q[2] = 16'h00B4;
        exp_q[3] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_d%0d", i), 32'(out_data), 32'(exp_q[i]));
            step();
        end
        chk("drain_v0", 32'(out_valid), 32'd0);
        chk("drain_c0", 32'(count),     32'd0);
        step();
        chk("pop_empty_c0", 32'(count), 32'd0);

        // Bubbles presented while the pipeline is stalled are ignored.
        dataoutv_in = 1'b1;
        stalled_in  = 1'b1;
        dataout_in  = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bub_c%0d", i), 32'(count),     32'd0);
            chk($sformatf("bub_v%0d", i), 32'(out_valid), 32'd0);
        end
        dataoutv_in = 1'b0;
        stalled_in  = 1'b0;

        // Asynchronous reset mid-stream discards buffered words.
        out_ready = 1'b0;
        push_word(16'h00C1);
        push_word(16'h00C2);
        push_word(16'h00C3);
        chk("pre_rst_c3", 32'(count),     32'd3);
        chk("pre_rst_s",  32'(stall_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_v", 32'(out_valid), 32'd0);
        chk("arst_c", 32'(count),     32'd0);
        chk("arst_s", 32'(stall_req), 32'd0);
        chk("arst_o", 32'(overflow),  32'd0);
        dataoutv_in = 1'b1;
        dataout_in  = 16'h0099;
        step();
        chk("rst_edge_c", 32'(count), 32'd0);
        dataoutv_in = 1'b0;
        reset_n     = 1'b1;
        push_word(16'h0055);
        chk("post_rst_d", 32'(out_data),  32'h0055);
        chk("post_rst_v", 32'(out_valid), 32'd1);
        chk("post_rst_c", 32'(count),     32'd1);

        // 300 drops on a full buffer: the counter saturates when it is built.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(16'(16'h0100 + i));
        end
        dataoutv_in = 1'b1;
        dataout_in  = 16'h0F0F;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        dataoutv_in = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 32'(EXP_DROPSAT));
        chk("sat_ovf",  32'(overflow), 32'd1);
        chk("sat_c4",   32'(count),    32'd4);
        chk("sat_head", 32'(out_data), 32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
